// File: rtl/cam_array_if.sv
// Bus bundle between the AP controller (master) and one CAM column (slave).
// Carries match_any only when CAM_MATCH_ANY_EN is defined.
interface cam_array_if #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1
);
    logic [ADDR_W-1:0]     addr_in;
    logic [CELL_QUANT-1:0] cell_wea_ctrl;
    logic                  sel_internal_col;
    logic                  cam_mode;
    logic [WORD_SIZE-1:0]  data_in;
    logic                  op_direction;
    logic [WORD_SIZE-1:0]  key_a;
    logic [WORD_SIZE-1:0]  key_b;
    logic [WORD_SIZE-1:0]  mask_a;
    logic [WORD_SIZE-1:0]  mask_b;
    logic                  wea;
    logic [CELL_QUANT-1:0] tags;
    logic [WORD_SIZE-1:0]  data_out;
`ifdef CAM_MATCH_ANY_EN
    logic                  match_any;

    modport master (
        output addr_in, cell_wea_ctrl, sel_internal_col, cam_mode, data_in,
               op_direction, key_a, key_b, mask_a, mask_b, wea,
        input  tags, data_out, match_any
    );
    modport slave (
        input  addr_in, cell_wea_ctrl, sel_internal_col, cam_mode, data_in,
               op_direction, key_a, key_b, mask_a, mask_b, wea,
        output tags, data_out, match_any
    );
`else
    modport master (
        output addr_in, cell_wea_ctrl, sel_internal_col, cam_mode, data_in,
               op_direction, key_a, key_b, mask_a, mask_b, wea,
        input  tags, data_out
    );
    modport slave (
        input  addr_in, cell_wea_ctrl, sel_internal_col, cam_mode, data_in,
               op_direction, key_a, key_b, mask_a, mask_b, wea,
        output tags, data_out
    );
`endif
endinterface

// File: rtl/cam_array.sv
// Bit-parallel CAM column: addressable RAM in normal mode, masked parallel compare/write in AP mode.
// Optional macro CAM_MATCH_ANY_EN adds match_any = OR of all tags.
module cam_array #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1
) (
    input logic         CLK100MHZ,
    input logic         rst,
    cam_array_if.slave  bus
);
    logic [WORD_SIZE-1:0] r_cells [CELL_QUANT];
    logic [WORD_SIZE-1:0] r_data_out;

    logic [WORD_SIZE-1:0] w_key       [CELL_QUANT];
    logic [WORD_SIZE-1:0] w_mask      [CELL_QUANT];
    logic [WORD_SIZE-1:0] w_cell_next [CELL_QUANT];
    logic [CELL_QUANT-1:0] w_wr_en;
    logic [WORD_SIZE-1:0] w_rd_data;

    genvar gi;
    generate
        for (gi = 0; gi < CELL_QUANT; gi++) begin : g_cell
            localparam logic PARITY = ((gi % 2) == 1);
            logic w_use_b;

            // In horizontal mode odd/even cells interleave the local and partner operands.
            assign w_use_b    = bus.op_direction && (PARITY != bus.sel_internal_col);
            assign w_key[gi]  = w_use_b ? bus.key_b  : bus.key_a;
            assign w_mask[gi] = w_use_b ? bus.mask_b : bus.mask_a;

            assign bus.tags[gi] = ~|((r_cells[gi] ^ w_key[gi]) & w_mask[gi]);

            assign w_wr_en[gi] = bus.cam_mode ? bus.cell_wea_ctrl[gi]
                                              : (bus.wea && (bus.addr_in == ADDR_W'(gi)));
            assign w_cell_next[gi] = bus.cam_mode
                ? ((r_cells[gi] & ~w_mask[gi]) | (bus.data_in & w_mask[gi]))
                : bus.data_in;
        end

        if ((1 << ADDR_W) == CELL_QUANT) begin : g_rd_full
            assign w_rd_data = r_cells[bus.addr_in];
        end else begin : g_rd_guard
            // Addresses beyond the last cell read as zero.
            assign w_rd_data = (int'(bus.addr_in) < CELL_QUANT) ? r_cells[bus.addr_in] : '0;
        end
    endgenerate

    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELL_QUANT; i++) begin
                r_cells[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CELL_QUANT; i++) begin
                if (w_wr_en[i]) begin
                    r_cells[i] <= w_cell_next[i];
                end
            end
        end
    end

    // Read samples the pre-edge contents, so a same-address write returns old data.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_rd_data;
        end
    end

    assign bus.data_out = r_data_out;

`ifdef CAM_MATCH_ANY_EN
    assign bus.match_any = |bus.tags;
`endif
endmodule

// File: tb/tb_cam_array.sv
// Directed plus randomized check of cam_array against a word-level behavioural model.
module tb_cam_array;
    localparam int W  = 8;
    localparam int CQ = 512;
    localparam int AW = $clog2(CQ);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0]  model [CQ];
    logic [W-1:0]  model_dout;

    cam_array_if #(.WORD_SIZE(W), .CELL_QUANT(CQ)) bus ();

    cam_array #(.WORD_SIZE(W), .CELL_QUANT(CQ)) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CQ-1:0] got, input logic [CQ-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [CQ-1:0] model_tags();
        logic [CQ-1:0] t;
        logic [W-1:0]  k, m;
        for (int i = 0; i < CQ; i++) begin
            if (bus.op_direction == 1'b1 && (i % 2) != int'(bus.sel_internal_col)) begin
                k = bus.key_b; m = bus.mask_b;
            end else begin
                k = bus.key_a; m = bus.mask_a;
            end
            t[i] = (((model[i] ^ k) & m) == '0);
        end
        return t;
    endfunction

    function automatic logic [W-1:0] cell_mask(input int i);
        if (bus.op_direction == 1'b1 && (i % 2) != int'(bus.sel_internal_col))
            return bus.mask_b;
        return bus.mask_a;
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        logic [W-1:0] rd;
        if (rst) begin
            rd = model[bus.addr_in];
            if (bus.cam_mode) begin
                for (int i = 0; i < CQ; i++)
                    if (bus.cell_wea_ctrl[i])
                        model[i] = (model[i] & ~cell_mask(i)) | (bus.data_in & cell_mask(i));
            end else if (bus.wea) begin
                model[bus.addr_in] = bus.data_in;
            end
            model_dout = rd;
        end else begin
            for (int i = 0; i < CQ; i++) model[i] = '0;
            model_dout = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nwrite(input int a, input logic [W-1:0] d);
        bus.cam_mode = 1'b0; bus.wea = 1'b1;
        bus.addr_in = AW'(a); bus.data_in = d;
        tick();
        bus.wea = 1'b0;
    endtask

    task automatic read_check(input int a, input logic [W-1:0] exp, input string tag);
        bus.addr_in = AW'(a);
        tick();
        check(tag, CQ'(bus.data_out), CQ'(exp));
        check({tag, "_model"}, CQ'(bus.data_out), CQ'(model_dout));
    endtask

    logic [CQ-1:0] ones;
    logic [CQ-1:0] rnd_ctrl;

    initial begin
        ones = '1;
        for (int i = 0; i < CQ; i++) model[i] = '0;
        model_dout = '0;
        bus.addr_in = '0; bus.cell_wea_ctrl = '0; bus.sel_internal_col = 1'b0;
        bus.cam_mode = 1'b0; bus.data_in = '0; bus.op_direction = 1'b0;
        bus.key_a = '0; bus.key_b = '0; bus.mask_a = 8'hFF; bus.mask_b = 8'hFF;
        bus.wea = 1'b0;

        // Reset then read
        #12;
        check("reset_dout", CQ'(bus.data_out), '0);
        rst = 1'b1;
        tick();
        read_check(5, 8'h00, "reset_read5");
        check("reset_tags", bus.tags, ones);

        // Normal write/read and read-before-write
        nwrite(3, 8'hA5);
        read_check(3, 8'hA5, "rd_a5");
        bus.wea = 1'b1; bus.data_in = 8'h11; bus.addr_in = AW'(3);
        tick();
        bus.wea = 1'b0;
        check("rbw_old", CQ'(bus.data_out), CQ'(8'hA5));
        tick();
        check("rbw_new", CQ'(bus.data_out), CQ'(8'h11));

        // Vertical compare
        nwrite(0, 8'h01); nwrite(1, 8'h03); nwrite(2, 8'h02); nwrite(3, 8'h00);
        bus.key_a = 8'h01; bus.mask_a = 8'h01; bus.op_direction = 1'b0;
        #1;
        check("vert_tags30", CQ'(bus.tags[3:0]), CQ'(4'b0011));
        check("vert_model", bus.tags, model_tags());
        bus.mask_a = 8'h00;
        #1;
        check("vert_mask0", bus.tags, ones);

        // Masked parallel write, wea ignored in AP mode
        bus.cam_mode = 1'b1; bus.mask_a = 8'h04; bus.data_in = 8'hFF;
        bus.cell_wea_ctrl = '0; bus.cell_wea_ctrl[1] = 1'b1; bus.cell_wea_ctrl[2] = 1'b1;
        bus.wea = 1'b1; bus.addr_in = AW'(0);
        tick();
        bus.wea = 1'b0; bus.cell_wea_ctrl = '0; bus.cam_mode = 1'b0;
        check("ap_rd_old0", CQ'(bus.data_out), CQ'(8'h01));
        read_check(1, 8'h07, "ap_cell1");
        read_check(2, 8'h06, "ap_cell2");
        read_check(0, 8'h01, "ap_cell0");

        // Horizontal compare
        nwrite(1, 8'h00);
        bus.op_direction = 1'b1; bus.sel_internal_col = 1'b0;
        bus.key_a = 8'h01; bus.key_b = 8'h00; bus.mask_a = 8'h01; bus.mask_b = 8'h01;
        #1;
        check("horiz_sel0", CQ'(bus.tags[1:0]), CQ'(2'b11));
        bus.sel_internal_col = 1'b1;
        #1;
        check("horiz_sel1", CQ'(bus.tags[1:0]), CQ'(2'b00));
        check("horiz_model", bus.tags, model_tags());

        // Async reset in the middle of an AP write
        bus.op_direction = 1'b0; bus.cam_mode = 1'b1; bus.cell_wea_ctrl = ones;
        bus.key_a = 8'h00; bus.mask_a = 8'hFF; bus.data_in = 8'h5A; bus.addr_in = AW'(2);
        #1;
        rst = 1'b0;
        for (int i = 0; i < CQ; i++) model[i] = '0;
        model_dout = '0;
        #1;
        check("arst_dout", CQ'(bus.data_out), '0);
        check("arst_tags", bus.tags, ones);
        tick();
        check("arst_hold_tags", bus.tags, ones);
        bus.cell_wea_ctrl = '0; bus.cam_mode = 1'b0;
        #1;
        rst = 1'b1;
        read_check(2, 8'h00, "arst_cell2");

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            bus.cam_mode = 1'($urandom_range(0, 1));
            bus.wea = 1'($urandom_range(0, 1));
            bus.addr_in = AW'($urandom_range(0, CQ - 1));
            bus.data_in = W'($urandom);
            bus.op_direction = 1'($urandom_range(0, 1));
            bus.sel_internal_col = 1'($urandom_range(0, 1));
            bus.key_a = W'($urandom); bus.key_b = W'($urandom);
            bus.mask_a = W'($urandom); bus.mask_b = W'($urandom);
            for (int i = 0; i < CQ; i++) rnd_ctrl[i] = ($urandom_range(0, 3) == 0);
            bus.cell_wea_ctrl = rnd_ctrl;
            tick();
            check("rnd_dout", CQ'(bus.data_out), CQ'(model_dout));
            check("rnd_tags", bus.tags, model_tags());
`ifdef CAM_MATCH_ANY_EN
            check("rnd_match_any", CQ'(bus.match_any), CQ'(|model_tags()));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
